mux4_lane_arbiter: RTL and testbench
====================================

# mux4_lane_arbiter

Upstream feeder for the 4-bit 4:1 mux stage (`mux4_1`). Four independent producer lanes each deposit a `WIDTH`-bit word into a one-entry holding register. A round-robin arbiter picks one full lane and drives `sel`. The mux output is therefore the granted lane's word, valid while `out_valid` is high. A valid/ready handshake toward the consumer clears the granted lane and advances the round-robin pointer.

## Interface
- `WIDTH`, 4: data width per lane. Must equal the mux data width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 4: per-lane write strobe. Bit i is lane i (0=w, 1=x, 2=y, 3=z).
- `in_ready` output 4: per-lane "holding register empty".
- `in_w`, `in_x`, `in_y`, `in_z` input WIDTH: per-lane write data.
- `w`, `x`, `y`, `z` output WIDTH: holding registers, wired to the mux data inputs.
- `sel` output 2: mux select. 00→w, 01→x, 10→y, 11→z.
- `out_valid` output 1: the word at the mux output (lane `sel`) is valid.
- `out_ready` input 1: the consumer accepts the word.

## Operation
- Reset values:
  - `full[3:0]`=0, so `in_ready`=4'b1111.
  - `w`/`x`/`y`/`z`=0.
  - `sel`=00.
  - `out_valid`=0.
  - `last_grant`=2'b11, so the first search starts at lane 0.
  - State is IDLE.
- Lane write: `in_ready[i]` = !`full[i]`, a pure register output with no combinational path from `out_ready`.
  - If `in_valid[i]` && `in_ready[i]`, capture the data and set `full[i]`.
  - `in_valid[i]` while full is ignored. Producers must hold until ready.
- Round-robin pick: search from `last_grant`+1 upward mod 4. Grant the first lane with `full`=1. Use pre-edge `full` only.
- FSM, 2 states:
  - IDLE, `out_valid`=0: if any `full` is set, load `sel` with the pick and go to PRESENT. Otherwise stay.
  - PRESENT, `out_valid`=1: `sel` and `full[sel]` are held while `out_ready`=0.
  - On `out_valid` && `out_ready`:
    - Clear `full[sel]` and set `last_grant`=`sel`.
    - Re-pick among the other full lanes, excluding `sel`, searching from `sel`+1.
    - If one exists, load `sel` with it and stay in PRESENT (back-to-back). Otherwise go to IDLE.
- Simultaneous events:
  - A lane written on the same edge as an accept is not a candidate for that edge's re-pick. It becomes eligible on the next cycle.
  - The lane being accepted cannot be refilled on the same edge, because its `in_ready` was 0.
- `w`/`x`/`y`/`z` change only on a lane write. Data on a full lane never changes.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pending words are discarded. `out_valid` drops without a handshake.

## Timing
- Write latency: write at edge k, then `in_ready[i]`=0 after k.
- Write-to-valid latency:
  - From IDLE: `out_valid`=1 with the correct `sel` after edge k+1.
  - From PRESENT: the word is presented after the edge that accepts the current word, unless lane i is picked later under round-robin order.
- Throughput: one word per cycle while lanes stay full and `out_ready`=1.
- Free lane: `in_ready[sel]` returns to 1 after the accepting edge. That lane can be rewritten on the next edge.
- All outputs are registered, except `in_ready`, which is a direct copy of `~full`, also registered.
- Downstream mux: the combinational path is `sel`/`w`..`z` → `output2`. The consumer samples `output2` in the same cycle as `out_valid` && `out_ready`.

## Structure
- Package `mux4_lane_pkg`:
  - `WIDTH_DEF`=4.
  - Lane constants `LANE_W`=2'd0, `LANE_X`=2'd1, `LANE_Y`=2'd2, `LANE_Z`=2'd3.
  - State enum `arb_state_t` {IDLE, PRESENT}.
- Sub-module `rr_pick4`, purely combinational.
  - Inputs: `req[3:0]`, `start[1:0]`.
  - Outputs: `found`, `idx[1:0]`.
  - Instantiated twice: the IDLE pick, and the re-pick with `req` = `full` & ~onehot(`sel`).

## Test plan
- **Reset:** assert `rst` mid-PRESENT with `full`=4'b1011 → outputs go to reset values immediately: `out_valid`=0, `in_ready`=4'b1111, `sel`=00, `w`..`z`=0.
- **Single lane:** write `in_y`=4'hA alone.
  - After 1 edge, `in_ready`=4'b1011.
  - After the next edge, `out_valid`=1, `sel`=10, mux `output2`=4'hA.
  - With `out_ready`=1, `in_ready` returns to 4'b1111 and the FSM returns to IDLE.
- **Round-robin:** write all four lanes (w=1, x=2, y=3, z=4) in one cycle, `out_ready`=1 constant → accepted words 1, 2, 3, 4 in consecutive cycles, `sel` 00, 01, 10, 11, then `out_valid`=0.
- **Backpressure:** lanes x=5 and z=7 are full, `out_ready`=0 for 5 cycles → `sel`=01 and `output2`=5 hold stable for all 5 cycles. A raised `out_ready` yields 5 then 7 back-to-back.
- **Fairness:** keep lane w continuously refilled, with lane z written once → z is granted no later than the second grant after its write. Lane w is never granted twice consecutively while z is full.
- **Same-edge refill:** accept x, and on the same edge write lane w with pointer `last_grant`=01 → the re-pick excludes w on that edge. w is presented next, after the other pending lanes per round-robin order. No word is lost or duplicated: a scoreboard compares against the write order per lane.

Source files
------------

// File: rtl/mux4_lane_pkg.sv
// Shared definitions for the four-lane feeder of the 4:1 mux stage.
//   WIDTH_DEF       default per-lane data width (matches the mux data width)
//   LANE_W..LANE_Z  lane indices, equal to the mux select codes
//   arb_state_t     arbiter FSM state
//   lane_onehot     lane index -> one-hot lane mask
package mux4_lane_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] LANE_W = 2'd0;
  localparam logic [1:0] LANE_X = 2'd1;
  localparam logic [1:0] LANE_Y = 2'd2;
  localparam logic [1:0] LANE_Z = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mux4_lane_arbiter_rr_pick4.sv
// Combinational four-way round-robin search.
//   req   [3:0]  candidate lanes
//   start [1:0]  first lane examined; the search wraps upward mod 4
//   found        at least one request is set
//   idx   [1:0]  first requesting lane at or after start (start when none)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[start + 2'(i)]) begin
        found = 1'b1;
        idx   = start + 2'(i);
      end
    end
  end

endmodule

// File: rtl/mux4_lane_arbiter.sv
// Four one-entry producer lanes feeding the 4:1 mux stage. A round-robin
// arbiter drives the mux select toward the granted full lane and hands the
// word to the consumer with a valid/ready handshake.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid / in_ready per-lane write strobe / holding register empty
//   in_w..in_z          per-lane write data
//   w, x, y, z          holding registers, wired to the mux data inputs
//   sel                 mux select (0=w 1=x 2=y 3=z)
//   out_valid/out_ready consumer handshake for the word on lane sel
//
// state   | meaning
// IDLE    | nothing presented; pick a full lane from last_grant+1
// PRESENT | lane sel presented; hold until accepted, then re-pick or idle
module mux4_lane_arbiter
  import mux4_lane_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready
);

  arb_state_t       r_state;
  logic [3:0]       r_full;
  logic [3:0]       r_in_ready;
  logic [1:0]       r_sel;
  logic [1:0]       r_last_grant;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_data [4];

  arb_state_t       w_next_state;
  logic [1:0]       w_next_sel;
  logic [1:0]       w_next_last;
  logic [3:0]       w_wr;
  logic [3:0]       w_clr;
  logic [3:0]       w_full_next;
  logic [WIDTH-1:0] w_din [4];

  logic             w_idle_found;
  logic [1:0]       w_idle_idx;
  logic             w_re_found;
  logic [1:0]       w_re_idx;

  assign w_din[0] = in_w;
  assign w_din[1] = in_x;
  assign w_din[2] = in_y;
  assign w_din[3] = in_z;

  // Writes are gated by the registered empty flag, so a lane being accepted
  // cannot be refilled on the same edge.
  assign w_wr        = in_valid & ~r_full;
  assign w_full_next = (r_full & ~w_clr) | w_wr;

  // Both searches look only at pre-edge full; lanes written on this edge
  // become candidates one cycle later.
  rr_pick4 u_pick_idle (
    .req   (r_full),
    .start (r_last_grant + 2'd1),
    .found (w_idle_found),
    .idx   (w_idle_idx)
  );

  rr_pick4 u_pick_next (
    .req   (r_full & ~lane_onehot(r_sel)),
    .start (r_sel + 2'd1),
    .found (w_re_found),
    .idx   (w_re_idx)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_last  = r_last_grant;
    w_clr        = 4'b0000;
    unique case (r_state)
      IDLE: begin
        if (w_idle_found) begin
          w_next_sel   = w_idle_idx;
          w_next_state = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_clr       = lane_onehot(r_sel);
          w_next_last = r_sel;
          if (w_re_found) begin
            w_next_sel = w_re_idx;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_full       <= 4'b0000;
      r_in_ready   <= 4'b1111;
      r_sel        <= LANE_W;
      r_last_grant <= LANE_Z;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_full       <= w_full_next;
      r_in_ready   <= ~w_full_next;
      r_sel        <= w_next_sel;
      r_last_grant <= w_next_last;
      r_out_valid  <= (w_next_state == PRESENT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr[i]) begin
          r_data[i] <= w_din[i];
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign w         = r_data[0];
  assign x         = r_data[1];
  assign y         = r_data[2];
  assign z         = r_data[3];

endmodule

// File: tb/tb_mux4_lane_arbiter.sv
module tb_mux4_lane_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_valid = 4'b0000;
  logic [3:0] in_ready;
  logic [3:0] in_w = 4'h0, in_x = 4'h0, in_y = 4'h0, in_z = 4'h0;
  logic [3:0] w, x, y, z;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mux4_lane_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mux4(input logic [1:0] s, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c,
                                      input logic [3:0] d);
    case (s)
      2'd0: return a;
      2'd1: return b;
      2'd2: return c;
      default: return d;
    endcase
  endfunction

  // Behavioural model: lane contents, who is presented, and last grant.
  bit         m_full [4];
  logic [3:0] m_data [4];
  int         m_last = 3;
  int         m_sel = 0;
  bit         m_valid = 0;
  bit         m_acc;
  bit         m_wr [4];
  int         m_pick;
  logic [3:0] lane_q [4][$];
  logic [3:0] acc_log[$];
  int         grant_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        m_full[l] = 0;
        m_data[l] = 4'h0;
        lane_q[l].delete();
      end
      m_last  = 3;
      m_sel   = 0;
      m_valid = 0;
    end else begin
      for (int l = 0; l < 4; l++) m_wr[l] = in_valid[l] && !m_full[l];
      m_acc  = m_valid && out_ready;
      m_pick = -1;
      if (!m_valid) begin
        for (int k = 1; k <= 4; k++)
          if (m_pick < 0 && m_full[(m_last + k) % 4]) m_pick = (m_last + k) % 4;
        if (m_pick >= 0) begin
          m_sel   = m_pick;
          m_valid = 1;
        end
      end else if (m_acc) begin
        m_full[m_sel] = 0;
        m_last = m_sel;
        for (int k = 1; k <= 3; k++)
          if (m_pick < 0 && m_full[(m_last + k) % 4]) m_pick = (m_last + k) % 4;
        if (m_pick >= 0) m_sel = m_pick;
        else m_valid = 0;
      end
      if (m_wr[0]) begin m_full[0] = 1; m_data[0] = in_w; lane_q[0].push_back(in_w); end
      if (m_wr[1]) begin m_full[1] = 1; m_data[1] = in_x; lane_q[1].push_back(in_x); end
      if (m_wr[2]) begin m_full[2] = 1; m_data[2] = in_y; lane_q[2].push_back(in_y); end
      if (m_wr[3]) begin m_full[3] = 1; m_data[3] = in_z; lane_q[3].push_back(in_z); end
    end
  end

  // Per-cycle compare against the model, plus a per-lane write-order scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, {~m_full[3], ~m_full[2], ~m_full[1], ~m_full[0]});
      chk("out_valid", out_valid, m_valid);
      chk("sel", sel, m_sel[1:0]);
      chk("w", w, m_data[0]);
      chk("x", x, m_data[1]);
      chk("y", y, m_data[2]);
      chk("z", z, m_data[3]);
      if (out_valid && out_ready) begin
        acc_log.push_back(mux4(sel, w, x, y, z));
        grant_log.push_back(int'(sel));
        if (lane_q[sel].size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("sb_order", mux4(sel, w, x, y, z), lane_q[sel].pop_front());
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    acc_log.delete();
    grant_log.delete();
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_in_ready", in_ready, 4'b1111);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sel", sel, 2'b00);

    // Single lane y
    in_valid = 4'b0100; in_y = 4'hA;
    cyc();
    in_valid = 4'b0000;
    chk("single_in_ready", in_ready, 4'b1011);
    chk("single_not_valid", out_valid, 1'b0);
    cyc();
    chk("single_valid", out_valid, 1'b1);
    chk("single_sel", sel, 2'b10);
    chk("single_mux", mux4(sel, w, x, y, z), 4'hA);
    out_ready = 1'b1;
    cyc();
    chk("single_freed", in_ready, 4'b1111);
    chk("single_idle", out_valid, 1'b0);

    // Round-robin over all four lanes
    do_reset();
    in_valid = 4'b1111; in_w = 4'h1; in_x = 4'h2; in_y = 4'h3; in_z = 4'h4;
    out_ready = 1'b1;
    cyc();
    in_valid = 4'b0000;
    repeat (6) cyc();
    chk("rr_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      chk("rr_word", acc_log[i], 4'(i + 1));
      chk("rr_sel", grant_log[i], i);
    end
    chk("rr_idle", out_valid, 1'b0);

    // Backpressure with x and z full
    do_reset();
    in_valid = 4'b1010; in_x = 4'h5; in_z = 4'h7;
    cyc();
    in_valid = 4'b0000;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_sel", sel, 2'b01);
      chk("bp_mux", mux4(sel, w, x, y, z), 4'h5);
      chk("bp_valid", out_valid, 1'b1);
      cyc();
    end
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("bp_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("bp_first", acc_log[0], 4'h5);
      chk("bp_second", acc_log[1], 4'h7);
    end

    // Fairness: w refilled continuously, z written once
    do_reset();
    in_valid = 4'b1001; in_w = 4'h1; in_z = 4'h6; out_ready = 1'b1;
    cyc();
    in_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      in_w = in_w + 4'h1;
      cyc();
    end
    in_valid = 4'b0000;
    repeat (4) cyc();
    chk("fair_min_grants", (grant_log.size() >= 2) ? 1 : 0, 1);
    if (grant_log.size() >= 2) begin
      chk("fair_g0", grant_log[0], 0);
      chk("fair_g1_is_z", grant_log[1], 3);
    end
    begin
      int zc = 0;
      foreach (grant_log[i]) if (grant_log[i] == 3) zc++;
      chk("fair_z_once", zc, 1);
    end

    // Same-edge refill of w while x is accepted
    do_reset();
    in_valid = 4'b1110; in_x = 4'h2; in_y = 4'h3; in_z = 4'h4;
    cyc();
    in_valid = 4'b0000;
    cyc();
    chk("refill_sel_x", sel, 2'b01);
    out_ready = 1'b1; in_valid = 4'b0001; in_w = 4'h9;
    cyc();
    in_valid = 4'b0000;
    chk("refill_repick_y", sel, 2'b10);
    chk("refill_w_full", in_ready[0], 1'b0);
    repeat (5) cyc();
    chk("refill_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk("refill_0", acc_log[0], 4'h2);
      chk("refill_1", acc_log[1], 4'h3);
      chk("refill_2", acc_log[2], 4'h4);
      chk("refill_3", acc_log[3], 4'h9);
    end
    chk("refill_idle", out_valid, 1'b0);

    // Reset in the middle of PRESENT with full=1011
    do_reset();
    in_valid = 4'b0001; in_w = 4'h5; out_ready = 1'b1;
    cyc();
    in_valid = 4'b0000;
    cyc();
    cyc();
    out_ready = 1'b0;
    in_valid = 4'b1011; in_w = 4'h1; in_x = 4'h2; in_z = 4'h4;
    cyc();
    in_valid = 4'b0000;
    cyc();
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_sel", sel, 2'b01);
    chk("pre_rst_in_ready", in_ready, 4'b0100);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 4'b1111);
    chk("mid_rst_sel", sel, 2'b00);
    chk("mid_rst_data", {w, x, y, z}, 16'h0000);
    rst = 1'b0;
    repeat (3) cyc();
    chk("post_rst_idle", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
